// File: rtl/spi_slave_core_if.sv
// Slot bus between mmio_sys and a slot core.
// The host side drives the strobes, address and write data. The core returns rd_data.
interface spi_slave_core_if;
  logic        cs;
  logic        read;
  logic        write;
  logic [4:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;

  modport master (output cs, read, write, addr, wr_data, input rd_data);
  modport slave  (input cs, read, write, addr, wr_data, output rd_data);
endinterface

// File: rtl/spi_slave_core.sv
// MMIO slot SPI responder. It exchanges full-duplex 8-bit MSB-first frames in all four CPOL/CPHA modes.
// The SPI pins are oversampled on clk through 2-FF synchronizers and a 1-FF edge detector.
module spi_slave_core (
  input  logic            clk,
  input  logic            reset,
  spi_slave_core_if.slave bus,
  input  logic            spi_sclk,
  input  logic            spi_mosi,
  input  logic            spi_ss_n,
  output logic            spi_miso,
  output logic            spi_miso_en
);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
  state_t state;

  logic sclk_p0, sclk_p1, sclk_p2;
  logic mosi_p0, mosi_p1;
  logic ss_p0, ss_p1, ss_p2;
  logic vld_p0, vld_p1;
  logic ss_armed;

  logic       cpol, cpha;
  logic [7:0] tx_buf, rx_data, shreg, rx_sh;
  logic       tx_full, rx_ready, overrun, underrun;
  logic [3:0] bit_cnt;

  logic sclk_rise, sclk_fall, lead, trail, sample, shift, ss_fall;
  logic wr_en, pop;
  logic [7:0] rx_byte;
  logic unused_ok;

  assign unused_ok = &{1'b0, bus.read, bus.wr_data[31:8]};

  assign sclk_rise = sclk_p1 & ~sclk_p2;
  assign sclk_fall = ~sclk_p1 & sclk_p2;
  assign lead      = cpol ? sclk_fall : sclk_rise;
  assign trail     = cpol ? sclk_rise : sclk_fall;
  assign sample    = cpha ? trail : lead;
  // With cpha=1, the first lead of a frame only frames the bit. It does not shift.
  assign shift     = cpha ? (lead && bit_cnt != 4'd0 && bit_cnt != 4'd8) : trail;
  // An ss_n fall counts only after ss_n has been seen high since reset.
  // This ignores a frame that was already running when reset was released.
  assign ss_fall   = ss_armed & ss_p2 & ~ss_p1;
  assign rx_byte   = {rx_sh[6:0], mosi_p1};

  assign wr_en = bus.cs & bus.write;
  assign pop   = wr_en && bus.addr == 5'd3;

  assign spi_miso_en = ~ss_p1;
  assign spi_miso    = (state == SHIFT) ? shreg[7] : 1'b1;

  always_comb begin
    bus.rd_data = 32'd0;
    case (bus.addr)
      5'd0:    bus.rd_data = {21'd0, underrun, overrun, rx_ready, rx_data};
      5'd1:    bus.rd_data = {29'd0, state != IDLE, tx_full, ~ss_p1};
      default: bus.rd_data = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sclk_p0  <= 1'b0;
      sclk_p1  <= 1'b0;
      sclk_p2  <= 1'b0;
      mosi_p0  <= 1'b0;
      mosi_p1  <= 1'b0;
      ss_p0    <= 1'b1;
      ss_p1    <= 1'b1;
      ss_p2    <= 1'b1;
      vld_p0   <= 1'b0;
      vld_p1   <= 1'b0;
      ss_armed <= 1'b0;
      state    <= IDLE;
      cpol     <= 1'b0;
      cpha     <= 1'b0;
      tx_buf   <= 8'd0;
      tx_full  <= 1'b0;
      rx_data  <= 8'd0;
      rx_ready <= 1'b0;
      overrun  <= 1'b0;
      underrun <= 1'b0;
      shreg    <= 8'hFF;
      rx_sh    <= 8'd0;
      bit_cnt  <= 4'd0;
    end else begin
      // p0/p1: synchronizers, p2: edge-detect history
      sclk_p0 <= spi_sclk;
      sclk_p1 <= sclk_p0;
      sclk_p2 <= sclk_p1;
      mosi_p0 <= spi_mosi;
      mosi_p1 <= mosi_p0;
      ss_p0   <= spi_ss_n;
      ss_p1   <= ss_p0;
      ss_p2   <= ss_p1;
      vld_p0  <= 1'b1;
      vld_p1  <= vld_p0;
      if (vld_p1 && ss_p1) ss_armed <= 1'b1;

      if (pop) rx_ready <= 1'b0;
      if (wr_en && bus.addr == 5'd2) begin
        cpol <= bus.wr_data[0];
        cpha <= bus.wr_data[1];
        if (bus.wr_data[2]) begin
          overrun  <= 1'b0;
          underrun <= 1'b0;
        end
      end

      if (ss_p1) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: if (ss_fall) state <= LOAD;
          LOAD: begin
            shreg   <= tx_full ? tx_buf : 8'hFF;
            if (tx_full) tx_full  <= 1'b0;
            else         underrun <= 1'b1;
            bit_cnt <= 4'd0;
            state   <= SHIFT;
          end
          SHIFT: begin
            if (sample && bit_cnt != 4'd8) begin
              bit_cnt <= bit_cnt + 4'd1;
              rx_sh   <= rx_byte;
              if (bit_cnt == 4'd7) begin
                rx_data  <= rx_byte;
                rx_ready <= 1'b1;
                if (rx_ready && !pop) overrun <= 1'b1;
              end
            end
            if (shift) begin
              shreg <= {shreg[6:0], 1'b1};
              if (bit_cnt == 4'd8) state <= LOAD;
            end
            // In cpha=1 the final shift is the next frame's first lead. That lead reloads instead.
            if (cpha && lead && bit_cnt == 4'd8) state <= LOAD;
          end
          default: state <= IDLE;
        endcase
      end

      // A same-cycle LOAD has already taken the old tx_buf, so the new byte stays pending.
      if (wr_en && bus.addr == 5'd1) begin
        tx_buf  <= bus.wr_data[7:0];
        tx_full <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_spi_slave_core.sv
// Directed bench for spi_slave_core.
// An SPI master model runs at f_clk/8. Expected values are hand-computed per scenario.
module tb_spi_slave_core;
  localparam int HALF = 40;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic spi_sclk = 1'b0, spi_mosi = 1'b0, spi_ss_n = 1'b1;
  logic spi_miso, spi_miso_en;
  logic m_cpol = 1'b0, m_cpha = 1'b0;
  int   n_checks = 0, n_fail = 0;
  logic [31:0] rd;
  logic [7:0]  rx;

  spi_slave_core_if bus();

  spi_slave_core dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .spi_sclk    (spi_sclk),
    .spi_mosi    (spi_mosi),
    .spi_ss_n    (spi_ss_n),
    .spi_miso    (spi_miso),
    .spi_miso_en (spi_miso_en)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.cs = 1'b1; bus.write = 1'b1; bus.addr = a; bus.wr_data = d;
    @(negedge clk);
    bus.cs = 1'b0; bus.write = 1'b0;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.cs = 1'b1; bus.read = 1'b1; bus.addr = a;
    #1 d = bus.rd_data;
    @(negedge clk);
    bus.cs = 1'b0; bus.read = 1'b0;
  endtask

  task automatic ss_low();
    spi_ss_n = 1'b0;
    #100;
  endtask

  task automatic ss_high();
    #(HALF);
    spi_ss_n = 1'b1;
    #100;
  endtask

  // Shifts n bits of tx, starting at bit index 'from'. Miso is captured into rx.
  task automatic spi_bits(input logic [7:0] tx, input int from, input int n, inout logic [7:0] r);
    for (int i = from; i > from - n; i--) begin
      if (!m_cpha) begin
        spi_mosi = tx[i];
        #(HALF);
        spi_sclk = ~m_cpol; r[i] = spi_miso;
        #(HALF);
        spi_sclk = m_cpol;
      end else begin
        spi_sclk = ~m_cpol; spi_mosi = tx[i];
        #(HALF);
        spi_sclk = m_cpol; r[i] = spi_miso;
        #(HALF);
      end
    end
  endtask

  task automatic spi_frame(input logic [7:0] tx, output logic [7:0] r);
    logic [7:0] t;
    t = 8'h00;
    ss_low();
    spi_bits(tx, 7, 8, t);
    ss_high();
    r = t;
  endtask

  initial begin
    bus.cs = 1'b0; bus.read = 1'b0; bus.write = 1'b0; bus.addr = 5'd0; bus.wr_data = 32'd0;
    repeat (4) @(negedge clk);
    bus_read(5'd0, rd); check_eq("rst_addr0", rd, 32'h0);
    bus_read(5'd1, rd); check_eq("rst_addr1", rd, 32'h0);
    check_eq("rst_miso", {31'd0, spi_miso}, 32'd1);
    check_eq("rst_miso_en", {31'd0, spi_miso_en}, 32'd0);
    reset = 1'b1;
    repeat (4) @(negedge clk);

    // mode 0, tx 0xA5, master sends 0x3C
    bus_write(5'd2, 32'h0);
    bus_write(5'd1, 32'hA5);
    bus_read(5'd1, rd); check_eq("t1_txfull", rd, 32'h2);
    rx = 8'h00;
    ss_low();
    check_eq("t1_miso_en", {31'd0, spi_miso_en}, 32'd1);
    bus_read(5'd1, rd); check_eq("t1_busy_sel", rd, 32'h5);
    spi_bits(8'h3C, 7, 8, rx);
    ss_high();
    check_eq("t1_master_rx", {24'd0, rx}, 32'hA5);
    bus_read(5'd0, rd); check_eq("t1_rx", {23'd0, rd[8:0]}, 32'h13C);
    bus_read(5'd1, rd); check_eq("t1_addr1", rd, 32'h0);
    check_eq("t1_idle_miso", {31'd0, spi_miso}, 32'd1);

    // mode 3, tx 0x81, master sends 0xF0
    bus_write(5'd3, 32'h0);
    bus_write(5'd2, 32'h7);
    m_cpol = 1'b1; m_cpha = 1'b1; spi_sclk = 1'b1;
    bus_write(5'd1, 32'h81);
    spi_frame(8'hF0, rx);
    check_eq("t2_master_rx", {24'd0, rx}, 32'h81);
    bus_read(5'd0, rd); check_eq("t2_addr0", rd, 32'h1F0);

    // overrun: two frames with no pop, then clear
    bus_write(5'd3, 32'h0);
    bus_write(5'd2, 32'h4);
    m_cpol = 1'b0; m_cpha = 1'b0; spi_sclk = 1'b0;
    spi_frame(8'h11, rx);
    spi_frame(8'h22, rx);
    bus_read(5'd0, rd); check_eq("t3_overrun", {22'd0, rd[9:0]}, 32'h322);
    bus_write(5'd2, 32'h4);
    bus_read(5'd0, rd); check_eq("t3_cleared", rd, 32'h122);

    // underrun: no tx write before the frame
    bus_write(5'd3, 32'h0);
    bus_read(5'd1, rd); check_eq("t4_txempty", rd, 32'h0);
    spi_frame(8'h00, rx);
    check_eq("t4_master_rx", {24'd0, rx}, 32'hFF);
    bus_read(5'd0, rd); check_eq("t4_addr0", rd, 32'h500);

    // aborted frame after 5 bits, then a full frame
    bus_write(5'd3, 32'h0);
    rx = 8'h00;
    ss_low();
    spi_bits(8'h5A, 7, 5, rx);
    ss_high();
    bus_read(5'd0, rd); check_eq("t5_abort", rd, 32'h400);
    spi_frame(8'h5A, rx);
    check_eq("t5_master_rx", {24'd0, rx}, 32'hFF);
    bus_read(5'd0, rd); check_eq("t5_addr0", rd, 32'h55A);

    // reset mid-frame after 4 bits; the remaining clocks must be ignored
    bus_write(5'd3, 32'h0);
    bus_write(5'd2, 32'h4);
    bus_write(5'd1, 32'h3C);
    rx = 8'h00;
    ss_low();
    spi_bits(8'hC3, 7, 4, rx);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    bus_read(5'd0, rd); check_eq("t6_rst_addr0", rd, 32'h0);
    bus_read(5'd1, rd); check_eq("t6_rst_addr1", rd, 32'h0);
    check_eq("t6_rst_miso_en", {31'd0, spi_miso_en}, 32'd0);
    check_eq("t6_rst_miso", {31'd0, spi_miso}, 32'd1);
    reset = 1'b1;
    spi_bits(8'hC3, 3, 4, rx);
    ss_high();
    bus_read(5'd0, rd); check_eq("t6_ignored", rd, 32'h0);
    bus_read(5'd1, rd); check_eq("t6_idle", rd, 32'h0);
    bus_write(5'd1, 32'h96);
    spi_frame(8'hC3, rx);
    check_eq("t6_master_rx", {24'd0, rx}, 32'h96);
    bus_read(5'd0, rd); check_eq("t6_rx", {23'd0, rd[8:0]}, 32'h1C3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
